// File: rtl/vga_pkg.sv
// vga_pkg: timing-record type and the two built-in VGA modes (shared by vga_timing_gen, optional VGA_FRAME_CNT_EN)
package vga_pkg;
    typedef struct packed {
        logic [10:0] h_tot;
        logic [10:0] h_sync_start;
        logic [10:0] h_sync_end;
        logic [10:0] h_blnk_start;
        logic [10:0] h_blnk_end;
        logic [10:0] v_tot;
        logic [10:0] v_sync_start;
        logic [10:0] v_sync_end;
        logic [10:0] v_blnk_start;
        logic [10:0] v_blnk_end;
    } vga_mode_t;
    localparam vga_mode_t MODE_1024X768 = '{
        11'd1344, 11'd1048, 11'd1184, 11'd1024, 11'd1344,
        11'd806, 11'd771, 11'd777, 11'd768, 11'd806
    };
    localparam vga_mode_t MODE_800X600 = '{
        11'd1056, 11'd840, 11'd968, 11'd800, 11'd1056,
        11'd628, 11'd601, 11'd605, 11'd600, 11'd628
    };
    // Legacy fixed-timing names kept for older draw stages
    localparam logic [10:0] HOR_TOTAL_TIME  = MODE_1024X768.h_tot;
    localparam logic [10:0] HOR_SYNC_START  = MODE_1024X768.h_sync_start;
    localparam logic [10:0] HOR_SYNC_END    = MODE_1024X768.h_sync_end;
    localparam logic [10:0] HOR_BLANK_START = MODE_1024X768.h_blnk_start;
    localparam logic [10:0] HOR_BLANK_END   = MODE_1024X768.h_blnk_end;
    localparam logic [10:0] VER_TOTAL_TIME  = MODE_1024X768.v_tot;
    localparam logic [10:0] VER_SYNC_START  = MODE_1024X768.v_sync_start;
    localparam logic [10:0] VER_SYNC_END    = MODE_1024X768.v_sync_end;
    localparam logic [10:0] VER_BLANK_START = MODE_1024X768.v_blnk_start;
    localparam logic [10:0] VER_BLANK_END   = MODE_1024X768.v_blnk_end;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: control inputs and timing outputs of vga_timing_gen (frame_cnt present with VGA_FRAME_CNT_EN)
interface vga_timing_gen_if #(parameter int CNT_W = 11);
    logic             ce;
    logic             mode_sel;
    logic             mode_active;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif
    modport master (
`ifdef VGA_FRAME_CNT_EN
        output frame_cnt,
`endif
        input  ce, mode_sel,
        output mode_active, hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
    );
    modport slave (
`ifdef VGA_FRAME_CNT_EN
        input  frame_cnt,
`endif
        output ce, mode_sel,
        input  mode_active, hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_decode.sv
// vga_timing_decode: half-open range compare of one counter for its sync and blanking windows
module vga_timing_decode #(parameter int CNT_W = 11) (
    input  logic [CNT_W-1:0] cnt,
    input  logic [10:0]      sync_start,
    input  logic [10:0]      sync_end,
    input  logic [10:0]      blnk_start,
    input  logic [10:0]      blnk_end,
    output logic             sync,
    output logic             blnk
);
    always_comb begin
        sync = cnt >= CNT_W'(sync_start) && cnt < CNT_W'(sync_end);
        blnk = cnt >= CNT_W'(blnk_start) && cnt < CNT_W'(blnk_end);
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode VGA counters/sync/blank, mode switch only at frame wrap (frame_cnt with VGA_FRAME_CNT_EN)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter vga_mode_t MODE0 = MODE_1024X768,
    parameter vga_mode_t MODE1 = MODE_800X600,
    parameter int        CNT_W = 11
) (
    input  logic clk,
    input  logic rst_n,
    vga_timing_gen_if.master vga
);
    logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic mode_q, mode_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic hblnk_q, hblnk_d, vblnk_q, vblnk_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic h_last, v_last, wrap;
    vga_mode_t cur, nxt;
    always_comb begin
        cur = mode_q ? MODE1 : MODE0;
        h_last = hcount_q == CNT_W'(cur.h_tot - 11'd1);
        v_last = vcount_q == CNT_W'(cur.v_tot - 11'd1);
        wrap = vga.ce && h_last && v_last;
        mode_d = wrap ? vga.mode_sel : mode_q;
        // decode uses the record of the frame the next counts belong to
        nxt = mode_d ? MODE1 : MODE0;
        hcount_d = !vga.ce ? hcount_q : h_last ? '0 : hcount_q + 1'b1;
        vcount_d = !(vga.ce && h_last) ? vcount_q : v_last ? '0 : vcount_q + 1'b1;
        line_start_d = vga.ce && h_last;
        frame_start_d = wrap;
    end
    vga_timing_decode #(.CNT_W(CNT_W)) u_h (
        .cnt(hcount_d), .sync_start(nxt.h_sync_start), .sync_end(nxt.h_sync_end),
        .blnk_start(nxt.h_blnk_start), .blnk_end(nxt.h_blnk_end), .sync(hsync_d), .blnk(hblnk_d)
    );
    vga_timing_decode #(.CNT_W(CNT_W)) u_v (
        .cnt(vcount_d), .sync_start(nxt.v_sync_start), .sync_end(nxt.v_sync_end),
        .blnk_start(nxt.v_blnk_start), .blnk_end(nxt.v_blnk_end), .sync(vsync_d), .blnk(vblnk_d)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            mode_q        <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            mode_q        <= mode_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    always_comb frame_cnt_d = frame_cnt_q + {15'd0, frame_start_d};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end
    assign vga.frame_cnt = frame_cnt_q;
`endif
    assign vga.mode_active = mode_q;
    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.hblnk       = hblnk_q;
    assign vga.vblnk       = vblnk_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule
